serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing a - b, LSB first, one bit per clock, using a single borrow flop.
- It is the subtract counterpart of the combinational ripple-carry adder in the arithmetic lab set.
- It trades WIDTH cycles of latency for one full-subtractor cell.
- A start/busy/done handshake lets a controller or testbench sequence operations.

Parameters:
- WIDTH, 5, operand width in bits. Legal range is 2..16.
- CNT_W, 3, bit-counter width. Must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request. Sampled only while idle.
- a  input  WIDTH  minuend. Sampled on the accepting edge.
- b  input  WIDTH  subtrahend. Sampled on the accepting edge.
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when diff/borrow become valid
- diff  output  WIDTH  (a - b) mod 2**WIDTH
- borrow  output  1  borrow out of the MSB. 1 iff a < b (unsigned).

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset is asynchronous and active-low (rst_n). Asserting it forces all state immediately; release is synchronous to clk.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow=0, internal shift registers, counter and borrow flop all 0.
- States: IDLE, RUN.
- IDLE:
  - On a rising edge with start=1, latch a into shift register SA and b into SB. Clear the borrow flop and the counter. Go to RUN; busy=1 from this edge.
  - start=0 leaves the state in IDLE.
- RUN, each edge, with bin = borrow flop and ai/bi = SA[0]/SB[0]:
  - d = ai ^ bi ^ bin
  - bout = (~ai & bi) | (~(ai ^ bi) & bin)
  - Shift d into the result shift register from the MSB end, so the first bit ends up at bit 0 after WIDTH shifts.
  - Shift SA and SB right by 1.
  - Borrow flop <= bout. Counter increments.
- Completion, on the edge where the counter reaches WIDTH-1 (the WIDTH-th RUN edge):
  - diff <= full result including this edge's d.
  - borrow <= bout.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start sampled at edge E0. done is high in the cycle after edge E0+WIDTH (5 edges for default WIDTH). Exactly WIDTH RUN edges.
- done is high for exactly one cycle. It clears on the next edge unless a new operation completes then, which is impossible for WIDTH >= 2.
- diff and borrow update only at completion. They hold their value through IDLE and through the next operation until it completes.
- start while busy=1 is ignored: no re-latch, no restart, no error.
- start during the done cycle (state already IDLE) is accepted normally. Back-to-back throughput is one result per WIDTH+1 cycles.
- Changes to a or b after the accepting edge have no effect on the operation in progress.
- Reset asserted mid-operation aborts it: all outputs return to reset values immediately and no done pulse is produced.
- Arithmetic: unsigned modulo 2**WIDTH. {borrow, diff} forms a WIDTH+1-bit two's-complement-style result. borrow=1 iff a < b; a == b gives diff=0, borrow=0.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release, no start for 10 cycles -> busy=0, done=0, diff=0, borrow=0 throughout.
- Basic subtract: a=13, b=6, start pulse -> busy for 5 cycles; done pulses once 5 edges after accept; diff=7, borrow=0; values held afterwards.
- Underflow and wrap: a=6, b=13 -> diff=25 (5'b11001), borrow=1. Then a=0, b=1 -> diff=31, borrow=1.
- Equal and extreme operands:
  - a=31, b=31 -> diff=0, borrow=0
  - a=31, b=0 -> diff=31, borrow=0
  - a=0, b=31 -> diff=1, borrow=1
- Handshake stress:
  - start held high continuously with a=20, b=3, with a/b changed to 1/1 while busy -> first result diff=17, borrow=0.
  - The next operation is accepted in the done cycle; results then arrive every 6 cycles.
  - A mid-run start has no effect.
- Reset mid-operation: start a=9, b=4, assert rst_n=0 on the 3rd RUN cycle -> outputs zero immediately, no done pulse. After release, a=9, b=4 -> diff=5, borrow=0.
- Compare every result against a reference model over a randomized sweep of all 1024 operand pairs.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit unsigned subtractor (a - b).
// One full-subtractor cell plus a borrow flop processes one bit per clock,
// LSB first. A start/busy/done handshake sequences operations; diff and
// borrow are registered and only change when an operation completes.
//
// Handshake: start is sampled only while idle (busy=0, including the done
// cycle). The accepting edge latches a and b and raises busy. busy stays
// high for exactly WIDTH cycles; done pulses for one cycle together with
// the new diff/borrow. start while busy is ignored.
//
// Parameter constraints: 2 <= WIDTH <= 16 and 2**CNT_W > WIDTH.

module serial_subtractor #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   sa;        // minuend, shifted right each RUN edge
    logic [WIDTH-1:0]   sb;        // subtrahend, shifted right each RUN edge
    logic [WIDTH-1:0]   res;       // partial result, filled from the MSB end
    logic               bflop;     // borrow between successive bit positions
    logic [CNT_W-1:0]   cnt;       // index of the bit being processed

    logic               ai;
    logic               bi;
    logic               d;
    logic               bout;
    logic [WIDTH-1:0]   next_res;
    logic               last_bit;

    // Full-subtractor cell on the current LSBs and the next result word.
    always_comb begin
        ai       = sa[0];
        bi       = sb[0];
        d        = ai ^ bi ^ bflop;
        bout     = (~ai & bi) | (~(ai ^ bi) & bflop);
        next_res = {d, res[WIDTH-1:1]};
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    // Control FSM plus datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            bflop  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        res   <= '0;
                        bflop <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res   <= next_res;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    bflop <= bout;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // Final bit: publish the full word and the MSB borrow.
                        diff   <= next_res;
                        borrow <= bout;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed vector table, hand-written
// handshake/reset sequences, and a shuffled sweep of every operand pair.

module tb_serial_subtractor;

    localparam int WIDTH = 5;
    localparam int CNT_W = 3;
    localparam int MAX_WAIT = 20;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH:0] exp_q[$];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] diff;
        logic             borrow;
        string            name;
    } vec_t;

    vec_t vecs[8];

    serial_subtractor #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .borrow(borrow)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until done is seen, bounded; returns edges taken.
    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < MAX_WAIT) begin
            step();
            edges++;
        end
    endtask

    // Driver: one full operation from idle, with latency/pulse/hold checks.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] ed, input logic eb, input string name);
        int edges;
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        check({name, " busy_after_accept"}, 32'(busy), 32'd1);
        wait_done(edges);
        check({name, " latency"}, 32'(edges), 32'(WIDTH));
        check({name, " result"}, 32'({eb, ed}), 32'({eb, ed}) ^ 32'({borrow, diff} ^ {eb, ed}));
        step();
        check({name, " done_one_cycle"}, 32'(done), 32'd0);
        check({name, " result_held"}, 32'({borrow, diff}), 32'({eb, ed}));
        check({name, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int edges;
        logic [9:0] pairs[1024];
        logic [WIDTH:0] expv;

        vecs[0] = '{a: 5'd13, b: 5'd6,  diff: 5'd7,  borrow: 1'b0, name: "13-6"};
        vecs[1] = '{a: 5'd6,  b: 5'd13, diff: 5'd25, borrow: 1'b1, name: "6-13"};
        vecs[2] = '{a: 5'd0,  b: 5'd1,  diff: 5'd31, borrow: 1'b1, name: "0-1"};
        vecs[3] = '{a: 5'd31, b: 5'd31, diff: 5'd0,  borrow: 1'b0, name: "31-31"};
        vecs[4] = '{a: 5'd31, b: 5'd0,  diff: 5'd31, borrow: 1'b0, name: "31-0"};
        vecs[5] = '{a: 5'd0,  b: 5'd31, diff: 5'd1,  borrow: 1'b1, name: "0-31"};
        vecs[6] = '{a: 5'd9,  b: 5'd4,  diff: 5'd5,  borrow: 1'b0, name: "9-4"};
        vecs[7] = '{a: 5'd20, b: 5'd3,  diff: 5'd17, borrow: 1'b0, name: "20-3"};

        // Reset then idle
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 32'({busy, done, borrow, diff}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle outputs", 32'({busy, done, borrow, diff}), 32'd0);
        end

        // Table-driven directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].name);
        end

        // Handshake stress: start held high, operands changed while busy
        a     = 5'd20;
        b     = 5'd3;
        start = 1'b1;
        step();
        a = 5'd1;
        b = 5'd1;
        check("stress busy", 32'(busy), 32'd1);
        wait_done(edges);
        check("stress first latency", 32'(edges), 32'(WIDTH));
        check("stress first result", 32'({borrow, diff}), 32'({1'b0, 5'd17}));
        step();
        check("stress accept in done cycle", 32'(busy), 32'd1);
        check("stress done cleared", 32'(done), 32'd0);
        a = 5'd7;
        b = 5'd2;
        wait_done(edges);
        check("stress second interval", 32'(edges + 1), 32'(WIDTH + 1));
        check("stress second result", 32'({borrow, diff}), 32'({1'b0, 5'd0}));
        step();
        check("stress third accept", 32'(busy), 32'd1);
        wait_done(edges);
        check("stress third interval", 32'(edges + 1), 32'(WIDTH + 1));
        check("stress third result", 32'({borrow, diff}), 32'({1'b0, 5'd5}));
        start = 1'b0;
        step();
        check("stress stop", 32'({busy, done}), 32'd0);

        // Reset mid-operation: prior result is 5, so the clear is visible
        a     = 5'd9;
        b     = 5'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midreset outputs", 32'({busy, done, borrow, diff}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("midreset held", 32'({busy, done, borrow, diff}), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("after reset no done", 32'({busy, done}), 32'd0);
        end
        run_op(5'd9, 5'd4, 5'd5, 1'b0, "9-4 after reset");

        // Shuffled sweep of every operand pair against the arithmetic model
        for (int i = 0; i < 1024; i++) pairs[i] = 10'(i);
        for (int i = 1023; i > 0; i--) begin
            int j;
            logic [9:0] t;
            j = int'($urandom_range(i, 0));
            t        = pairs[i];
            pairs[i] = pairs[j];
            pairs[j] = t;
        end
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] p;
            p = pairs[i];
            a = p[9:5];
            b = p[4:0];
            exp_q.push_back({1'b0, p[9:5]} - {1'b0, p[4:0]});
            start = 1'b1;
            step();
            start = 1'b0;
            wait_done(edges);
            expv = exp_q.pop_front();
            if (edges != WIDTH) begin
                check("sweep latency", 32'(edges), 32'(WIDTH));
            end
            check("sweep result", 32'({borrow, diff}), 32'(expv));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
